// File: rtl/pkt_load_ctrl.sv
// pkt_load_ctrl
// Assembles 3-byte pixel packets from a UART byte stream, writes each accepted
// pixel into the image RAM, and launches the CPU once a full image has arrived.
//
// State table
//   B0     | waiting for a header byte (rx_byte[7:5] == 3'b101)
//   B1     | header stored, waiting for second byte
//   B2     | two bytes stored, waiting for third byte
//   COMMIT | one cycle: write pixel / count error, decide next load or run
//   RUN    | CPU running; rx bytes ignored until cpu_done
//
// Packet layout {b0,b1,b2} = {hdr[2:0], loc[9:0], data[7:0], footer[2:0]}
//
// Build option: define PKT_FOOTER_CHECK_EN to reject packets whose footer
// parity does not match. Without it only the header and loc range gate
// acceptance; the port list is identical in both builds.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   rx_valid       in   one-cycle strobe, rx_byte valid
//   rx_byte[7:0]   in   received UART byte
//   ram_we         out  image RAM write strobe (COMMIT of a good packet)
//   ram_addr[9:0]  out  image RAM pixel address
//   ram_wdata[7:0] out  image RAM pixel data
//   cpu_start      out  one-cycle pulse, first cycle of RUN
//   cpu_done       in   CPU completion (level or pulse), honoured in RUN only
//   busy           out  high while in RUN
//   count_packets  out  accepted packets in the current load
//   err_count      out  rejected packets, saturating

module pkt_load_ctrl #(
    parameter int NUM_PIXELS = 785,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic        busy,
    output logic [31:0] count_packets,
    output logic [15:0] err_count
);

    localparam int          TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] NP       = NUM_PIXELS;
    localparam logic [TW-1:0] TLOAD  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_B0     = 3'd0,
        S_B1     = 3'd1,
        S_B2     = 3'd2,
        S_COMMIT = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Only the packet fields that are actually consumed are kept.
    logic [4:0]    loc_hi;
    logic [7:0]    mid_q;
    logic [4:0]    data_lo;
    logic [TW-1:0] timer;
    logic          run_first;

    logic [9:0]    loc;
    logic [7:0]    data;
    logic          hdr_ok;
    logic          loc_ok;
    logic          pkt_ok;
    logic          in_body;
    logic          timed_out;
    logic          load_timer;
    logic          last_pixel;

    assign loc     = {loc_hi, mid_q[7:3]};
    assign data    = {mid_q[2:0], data_lo};
    assign hdr_ok  = (rx_byte[7:5] == 3'b101);
    assign loc_ok  = ({22'd0, loc} < NP);
    assign in_body = (state == S_B1) || (state == S_B2);

`ifdef PKT_FOOTER_CHECK_EN
    logic [2:0] foot_q;
    logic [2:0] foot_exp;

    assign foot_exp = {^data, ^loc, ^{data[7:4], loc[9:5]}};
    assign pkt_ok   = loc_ok && (foot_q == foot_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foot_q <= 3'd0;
        end else if (state == S_B2 && rx_valid) begin
            foot_q <= rx_byte[2:0];
        end
    end
`else
    assign pkt_ok = loc_ok;
`endif

    // Timer reaches zero on the TIMEOUT-th consecutive idle cycle in B1/B2.
    assign timed_out  = in_body && !rx_valid && (timer == '0);
    assign last_pixel = pkt_ok && ((count_packets + 32'd1) == NP);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_B0;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_B0: begin
                if (rx_valid && hdr_ok) begin
                    next_state = S_B1;
                end
            end
            S_B1: begin
                if (rx_valid) begin
                    next_state = S_B2;
                end else if (timed_out) begin
                    next_state = S_B0;
                end
            end
            S_B2: begin
                if (rx_valid) begin
                    next_state = S_COMMIT;
                end else if (timed_out) begin
                    next_state = S_B0;
                end
            end
            S_COMMIT: begin
                // A byte arriving during COMMIT is a fresh header candidate,
                // except when this packet completes the image.
                if (last_pixel) begin
                    next_state = S_RUN;
                end else if (rx_valid && hdr_ok) begin
                    next_state = S_B1;
                end else begin
                    next_state = S_B0;
                end
            end
            S_RUN: begin
                if (cpu_done) begin
                    next_state = S_B0;
                end
            end
            default: next_state = S_B0;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        ram_we    = (state == S_COMMIT) && pkt_ok;
        ram_addr  = loc;
        ram_wdata = data;
        busy      = (state == S_RUN);
        cpu_start = (state == S_RUN) && run_first;
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    assign load_timer = rx_valid && (((state == S_B0 || state == S_COMMIT) && next_state == S_B1)
                                     || state == S_B1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loc_hi  <= 5'd0;
            mid_q   <= 8'd0;
            data_lo <= 5'd0;
        end else begin
            if ((state == S_B0 || state == S_COMMIT) && next_state == S_B1) begin
                loc_hi <= rx_byte[4:0];
            end
            if (state == S_B1 && rx_valid) begin
                mid_q <= rx_byte;
            end
            if (state == S_B2 && rx_valid) begin
                data_lo <= rx_byte[7:3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (load_timer) begin
            timer <= TLOAD;
        end else if (in_body && !rx_valid && timer != '0) begin
            timer <= timer - 1'b1;
        end else if (!in_body) begin
            timer <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_packets <= 32'd0;
        end else if (state == S_COMMIT && pkt_ok) begin
            count_packets <= count_packets + 32'd1;
        end else if (state == S_RUN && cpu_done) begin
            count_packets <= 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'd0;
        end else if (((state == S_COMMIT) && !pkt_ok) || timed_out) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Marks the first RUN cycle so cpu_start is a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_first <= 1'b0;
        end else begin
            run_first <= (state == S_COMMIT) && (next_state == S_RUN);
        end
    end

endmodule

// File: tb/tb_pkt_load_ctrl.sv
module tb_pkt_load_ctrl;

    localparam int NP = 8;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        cpu_done = 1'b0;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        cpu_start;
    logic        busy;
    logic [31:0] count_packets;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    pkt_load_ctrl #(.NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .cpu_start(cpu_start),
        .cpu_done(cpu_done),
        .busy(busy),
        .count_packets(count_packets),
        .err_count(err_count)
    );

    int total = 0;
    int bad   = 0;

    // scoreboard
    logic [17:0] exp_q[$];
    bit          start_q[$];

    // reference model state
    int          m_nb = 0;
    int          m_count = 0;
    int          m_err = 0;
    int          m_idle = 0;
    bit          m_run = 1'b0;
    logic [7:0]  m_b[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] mk(input int loc_i, input logic [7:0] data, input int flip);
        logic [9:0] l;
        logic [2:0] f;
        l = loc_i[9:0];
        f = {^data, ^l, ^{data[7:4], l[9:5]}};
        if (flip >= 0 && flip < 3) f[flip] = ~f[flip];
        return {3'b101, l, data, f};
    endfunction

    function automatic void err_inc();
        if (m_err < 65535) m_err++;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [9:0] loc;
        logic [7:0] data;
        logic [2:0] f;
        bit ok;
        m_idle = 0;
        if (m_run) return;
        if (m_nb == 0) begin
            if (b[7:5] == 3'b101) begin
                m_b[0] = b;
                m_nb = 1;
            end
            return;
        end
        m_b[m_nb] = b;
        m_nb++;
        if (m_nb < 3) return;
        m_nb = 0;
        loc  = {m_b[0][4:0], m_b[1][7:3]};
        data = {m_b[1][2:0], m_b[2][7:3]};
        f    = m_b[2][2:0];
        ok   = (int'(loc) < NP);
`ifdef PKT_FOOTER_CHECK_EN
        if (f != {^data, ^loc, ^{data[7:4], loc[9:5]}}) ok = 1'b0;
`endif
        if (ok) begin
            exp_q.push_back({loc, data});
            m_count++;
            if (m_count == NP) begin
                m_run = 1'b1;
                start_q.push_back(1'b1);
            end
        end else begin
            err_inc();
        end
    endfunction

    function automatic void model_idle();
        if (!m_run && m_nb != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_nb = 0;
                err_inc();
            end
        end
    endfunction

    task automatic cyc(input bit v, input logic [7:0] b, input bit done);
        rx_valid = v;
        rx_byte  = b;
        cpu_done = done;
        if (v) model_byte(b);
        else model_idle();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        cpu_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, count_packets, m_count);
        check({tag, "_err"}, {16'd0, err_count}, m_err);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_run});
    endtask

    task automatic handle_run();
        idle(2);
        check_state("run_entry");
        cyc(1'b1, 8'hA0, 1'b0);
        cyc(1'b1, 8'h29, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0);
        idle(2);
        check_state("run_ignore");
        cyc(1'b0, 8'h00, 1'b1);
        m_run = 1'b0;
        m_count = 0;
        check_state("run_done");
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
        if (m_run) handle_run();
    endtask

    task automatic send3(input logic [23:0] p, input int gap);
        send(p[23:16]);
        idle(gap);
        send(p[15:8]);
        idle(gap);
        send(p[7:0]);
    endtask

    task automatic settle(input string tag);
        idle(3);
        check_state(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_addr"}, {22'd0, ram_addr}, 32'd0);
        check({tag, "_wdata"}, {24'd0, ram_wdata}, 32'd0);
        check({tag, "_start"}, {31'd0, cpu_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_count"}, count_packets, 32'd0);
        check({tag, "_err"}, {16'd0, err_count}, 32'd0);
    endtask

    initial begin
        logic [23:0] p;
        logic [7:0]  g;
        int          r;

        fork
            forever begin
                @(negedge clk);
                if (ram_we) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ram_write unexpected actual addr=%0d data=%h required none",
                                 ram_addr, ram_wdata);
                    end else begin
                        logic [17:0] e;
                        e = exp_q.pop_front();
                        check("ram_write", {14'd0, ram_addr, ram_wdata}, {14'd0, e});
                    end
                end
                if (cpu_start) begin
                    if (start_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL cpu_start unexpected actual=1 required=0");
                    end else begin
                        void'(start_q.pop_front());
                        check("start_busy", {31'd0, busy}, 32'd1);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // canonical packet
        send3(24'hA02_9E0, 0);
        settle("basic");

        // bad footer
        send3(24'hA0_29_E1, 0);
        settle("footer");

        // non-header byte is silently discarded
        send(8'h20);
        send3(24'hA0_29_E0, 1);
        settle("resync");

        // timeout after a lone header
        send(8'hA0);
        idle(TO + 1);
        send3(24'hA0_29_E0, 0);
        settle("timeout");

        // longest gap that does not time out
        send(8'hA0);
        idle(TO - 1);
        send(8'h29);
        idle(TO - 1);
        send(8'hE0);
        settle("gap_edge");

        // loc range boundary
        send3(mk(NP, 8'h55, -1), 0);
        send3(mk(NP - 1, 8'hC3, -1), 0);
        settle("loc_edge");

        // back-to-back packets: second header arrives during COMMIT
        send3(mk(2, 8'h11, -1), 0);
        send3(mk(2, 8'h22, -1), 0);
        settle("b2b");

        // stray cpu_done outside RUN
        cyc(1'b0, 8'h00, 1'b1);
        send(8'hA3);
        cyc(1'b0, 8'h00, 1'b1);
        send(8'h00);
        send(8'h08);
        settle("stray_done");

        // reset mid-packet
        send(8'hA0);
        send(8'h29);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        m_nb = 0; m_count = 0; m_err = 0; m_idle = 0; m_run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);
        send3(24'hA0_29_E0, 0);
        settle("after_rst");

        // fill the image to reach RUN
        r = NP - m_count;
        for (int i = 0; i < r; i++) send3(mk(i, 8'(8'h40 + i), -1), 0);
        settle("image_done");

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                g = 8'($urandom);
                if (g[7:5] == 3'b101) g[7] = 1'b0;
                send(g);
            end else if (r == 1) begin
                p = mk($urandom_range(0, NP + 1), 8'($urandom), -1);
                send(p[23:16]);
                if ($urandom_range(0, 1) == 1) send(p[15:8]);
                idle(TO + $urandom_range(0, 3));
            end else if (r == 2) begin
                cyc(1'b0, 8'h00, 1'b1);
            end else begin
                int flip;
                flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
                p = mk($urandom_range(0, NP + 1), 8'($urandom), flip);
                send3(p, $urandom_range(0, 2));
                idle($urandom_range(0, 2));
            end
            if (it % 25 == 24) settle("random");
        end

        idle(TO + 5);
        check_state("final");
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("start_q_drained", start_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
